// File: rtl/spi_pkg.sv
// Shared widths, defaults and helpers for the SPI register bank.
package spi_pkg;

    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam logic [BYTE_W-1:0] RST_VAL_DEF = 8'h00;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BYTE_W-1:0] byte_t;

    // The command stage has already post-incremented addr when a data byte lands.
    function automatic addr_t wr_target(input addr_t a);
        return a - addr_t'(1);
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Bus between the SPI address/command stage (master) and the register bank (slave).
interface spi_reg_bank_if;
    import spi_pkg::*;

    logic  cs;
    logic  is_write;
    addr_t addr;
    byte_t wdata;
    logic  wr_stb;
    addr_t wr_addr;
    logic  miso;

    modport master (output cs, is_write, addr, wdata, input wr_stb, wr_addr, miso);
    modport slave  (input cs, is_write, addr, wdata, output wr_stb, wr_addr, miso);

endinterface

// File: rtl/spi_miso_shifter.sv
// MSB-first parallel-load shift register driving miso.
module spi_miso_shifter
    import spi_pkg::*;
(
    input  logic  spi_clk,
    input  logic  rstn,
    input  logic  load,
    input  logic  shift,
    input  byte_t data,
    output logic  miso
);

    byte_t sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = data;
        end else if (shift) begin
            sh_d = {sh_q[BYTE_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign miso = sh_q[BYTE_W-1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-addressed register bank with write strobe; serial readback only when
// SPI_READBACK_EN is defined, otherwise miso is tied low.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter byte_t       RST_VAL  = RST_VAL_DEF
) (
    input  logic                       spi_clk,
    input  logic                       rstn,
    spi_reg_bank_if.slave              bus,
    output logic [NUM_REGS*BYTE_W-1:0] regs_out
);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic       wr_stb_q, wr_stb_d;
    addr_t      wr_addr_q, wr_addr_d;
    byte_t      regs_q [NUM_REGS];
    byte_t      regs_d [NUM_REGS];

    logic  load_ev, write_ev, tgt_ok;
    addr_t tgt;

    // A byte boundary after the command byte: edges 9, 17, 25, ...
    assign load_ev  = bus.cs && (bit_cnt_q == 3'd0) && (byte_cnt_q != 2'd0);
    assign write_ev = load_ev && (byte_cnt_q == 2'd2) && bus.is_write;
    assign tgt      = wr_target(bus.addr);
    assign tgt_ok   = 32'(tgt) < NUM_REGS;

    always_comb begin
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        regs_d     = regs_q;
        if (bus.cs) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            byte_cnt_d = byte_cnt_q;
            if (bit_cnt_q == 3'd7 && byte_cnt_q != 2'd2) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
            if (write_ev && tgt_ok) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = tgt;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (tgt == ADDR_W'(i)) regs_d[i] = bus.wdata;
                end
            end
        end
    end

    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_out[BYTE_W*i +: BYTE_W] = regs_q[i];
    end

    assign bus.wr_stb  = wr_stb_q;
    assign bus.wr_addr = wr_addr_q;

`ifdef SPI_READBACK_EN
    byte_t rdata, sh_data;
    logic  sh_load;

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bus.addr == ADDR_W'(i)) rdata = regs_q[i];
        end
    end

    // Loading zero while deselected clears miso without a separate clear input.
    assign sh_load = !bus.cs || (load_ev && !bus.is_write);
    assign sh_data = bus.cs ? rdata : '0;

    spi_miso_shifter u_shifter (
        .spi_clk (spi_clk),
        .rstn    (rstn),
        .load    (sh_load),
        .shift   (bus.cs),
        .data    (sh_data),
        .miso    (bus.miso)
    );
`else
    assign bus.miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: write vectors, bursts, readback, abort and reset.
module tb_spi_reg_bank;
    import spi_pkg::*;

    localparam int unsigned NREG = 32;
    localparam byte_t       RVAL = 8'h00;

    logic spi_clk = 1'b0;
    logic rstn    = 1'b0;
    logic [NREG*8-1:0] regs_out;

    spi_reg_bank_if bus ();

    spi_reg_bank #(
        .NUM_REGS (NREG),
        .RST_VAL  (RVAL)
    ) dut (
        .spi_clk  (spi_clk),
        .rstn     (rstn),
        .bus      (bus),
        .regs_out (regs_out)
    );

    always #5 spi_clk = ~spi_clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        addr_t a;
        byte_t d;
    } wr_t;
    wr_t   sb [$];
    byte_t model [NREG];

    typedef struct {
        addr_t addr;
        byte_t data;
        logic  exp_stb;
        addr_t exp_addr;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name);
        logic [NREG*8-1:0] exp;
        for (int i = 0; i < NREG; i++) exp[8*i +: 8] = model[i];
        checks++;
        if (regs_out !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, regs_out, exp);
        end
    endtask

    task automatic tick(input logic c, input logic w, input addr_t a, input byte_t d);
        @(negedge spi_clk);
        bus.cs       = c;
        bus.is_write = w;
        bus.addr     = a;
        bus.wdata    = d;
        @(posedge spi_clk);
        #1;
    endtask

    task automatic expect_write(input addr_t t, input byte_t d);
        sb.push_back('{a: t, d: d});
        model[t[4:0]] = d;
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    always @(posedge spi_clk) begin
        #1;
        if (bus.wr_stb === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr_stb actual=%0h expected=none", bus.wr_addr);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("sb_wr_addr", 32'(bus.wr_addr), 32'(e.a));
                check("sb_reg_data", 32'(regs_out[8*e.a[4:0] +: 8]), 32'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd_exp;

        vecs[0] = '{addr: 7'h06, data: 8'h3C, exp_stb: 1'b1, exp_addr: 7'h05};
        vecs[1] = '{addr: 7'h01, data: 8'h11, exp_stb: 1'b1, exp_addr: 7'h00};
        vecs[2] = '{addr: 7'h20, data: 8'h77, exp_stb: 1'b1, exp_addr: 7'h1F};
        vecs[3] = '{addr: 7'h21, data: 8'hBB, exp_stb: 1'b0, exp_addr: 7'h00};
        vecs[4] = '{addr: 7'h00, data: 8'hCC, exp_stb: 1'b0, exp_addr: 7'h00};
        vecs[5] = '{addr: 7'h14, data: 8'h5A, exp_stb: 1'b1, exp_addr: 7'h13};

        for (int i = 0; i < NREG; i++) model[i] = RVAL;
        bus.cs = 1'b0; bus.is_write = 1'b0; bus.addr = '0; bus.wdata = '0;
        #12;
        check("rst_wr_stb", 32'(bus.wr_stb), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_miso", 32'(bus.miso), 0);
        check_regs("rst_regs");
        rstn = 1'b1;
        tick(1'b0, 1'b0, '0, '0);

        // Single-byte write frames, including out-of-range and wrap targets.
        for (int v = 0; v < 6; v++) begin
            for (int e = 1; e <= 16; e++) tick(1'b1, 1'b1, 7'h05, 8'hE1);
            if (vecs[v].exp_stb) expect_write(vecs[v].exp_addr, vecs[v].data);
            tick(1'b1, 1'b1, vecs[v].addr, vecs[v].data);
            check($sformatf("vec%0d_wr_stb", v), 32'(bus.wr_stb), 32'(vecs[v].exp_stb));
            tick(1'b0, 1'b0, '0, '0);
            check($sformatf("vec%0d_bit_cnt", v), 32'(dut.bit_cnt_q), 0);
            check($sformatf("vec%0d_stb_clear", v), 32'(bus.wr_stb), 0);
            check_regs($sformatf("vec%0d_regs", v));
        end

        // Burst across the top of the bank: target 31 kept, 32 and 33 dropped.
        for (int e = 1; e <= 16; e++) tick(1'b1, 1'b1, 7'h1F, 8'h00);
        expect_write(7'h1F, 8'hD0);
        tick(1'b1, 1'b1, 7'h20, 8'hD0);
        check("burst0_stb", 32'(bus.wr_stb), 1);
        for (int e = 18; e <= 24; e++) tick(1'b1, 1'b1, 7'h21, 8'hD1);
        tick(1'b1, 1'b1, 7'h21, 8'hD1);
        check("burst1_stb", 32'(bus.wr_stb), 0);
        for (int e = 26; e <= 32; e++) tick(1'b1, 1'b1, 7'h22, 8'hD2);
        tick(1'b1, 1'b1, 7'h22, 8'hD2);
        check("burst2_stb", 32'(bus.wr_stb), 0);
        tick(1'b0, 1'b0, '0, '0);
        check_regs("burst_regs");

        // Seed reg4/reg5 for the readback frame.
        for (int e = 1; e <= 16; e++) tick(1'b1, 1'b1, 7'h05, 8'h00);
        expect_write(7'h04, 8'hA5);
        tick(1'b1, 1'b1, 7'h05, 8'hA5);
        for (int e = 18; e <= 24; e++) tick(1'b1, 1'b1, 7'h06, 8'h0F);
        expect_write(7'h05, 8'h0F);
        tick(1'b1, 1'b1, 7'h06, 8'h0F);
        tick(1'b0, 1'b0, '0, '0);
        check_regs("seed_regs");

`ifdef SPI_READBACK_EN
        rd_exp = 16'hA50F;
`else
        rd_exp = 16'h0000;
`endif
        for (int e = 1; e <= 24; e++) begin
            tick(1'b1, 1'b0, (e < 17) ? 7'h04 : 7'h05, 8'h00);
            if (e >= 9) check($sformatf("read_e%0d_miso", e), 32'(bus.miso), 32'(rd_exp[24 - e]));
        end
        tick(1'b0, 1'b0, '0, '0);
        check("read_end_miso", 32'(bus.miso), 0);

        // Abort a write frame at edge 14 and a read frame at edge 12.
        for (int e = 1; e <= 13; e++) tick(1'b1, 1'b1, 7'h03, 8'hEE);
        tick(1'b0, 1'b1, 7'h03, 8'hEE);
        check("abort_wr_stb", 32'(bus.wr_stb), 0);
        check("abort_miso", 32'(bus.miso), 0);
        for (int e = 1; e <= 11; e++) tick(1'b1, 1'b0, 7'h04, 8'h00);
        tick(1'b0, 1'b0, 7'h04, 8'h00);
        check("abort_rd_miso", 32'(bus.miso), 0);
        tick(1'b0, 1'b0, '0, '0);
        check_regs("abort_regs");

        // Reset pulsed around edge 20 of a write burst.
        for (int e = 1; e <= 16; e++) tick(1'b1, 1'b1, 7'h03, 8'h00);
        expect_write(7'h02, 8'h99);
        tick(1'b1, 1'b1, 7'h03, 8'h99);
        tick(1'b1, 1'b1, 7'h04, 8'h55);
        tick(1'b1, 1'b1, 7'h04, 8'h55);
        @(negedge spi_clk);
        rstn = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) model[i] = RVAL;
        check_regs("rst_mid_regs");
        check("rst_mid_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_mid_bit_cnt", 32'(dut.bit_cnt_q), 0);
        check("rst_mid_miso", 32'(bus.miso), 0);
        #2;
        rstn = 1'b1;
        @(posedge spi_clk);
        #1;
        check("rst_release_stb", 32'(bus.wr_stb), 0);
        tick(1'b1, 1'b1, 7'h10, 8'h44);
        check("rst_after_stb", 32'(bus.wr_stb), 0);
        tick(1'b0, 1'b0, '0, '0);
        check_regs("rst_after_regs");

        check("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter: NUM_REGS, default 32, number of implemented 8-bit registers (1..128).
REQ-002 Parameter: RST_VAL, default 8'h00, value every register takes on reset.
REQ-003 Port: spi_clk  input  1  free-running SPI clock; all state on its rising edge.
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: cs  input  1  active-high frame select, sampled synchronously on spi_clk.
REQ-006 Port: is_write  input  1  transaction direction from the address/command stage; 1 = write.
REQ-007 Port: addr  input  7  register address from the address/command stage; already post-incremented when each data byte lands.
REQ-008 Port: wdata  input  8  last completed data byte from the address/command stage.
REQ-009 Port: regs_out  output  NUM_REGS*8  flat register contents; register n occupies bits [8n+7:8n].
REQ-010 Port: wr_stb  output  1  one-cycle pulse on each committed write.
REQ-011 Port: wr_addr  output  7  address of the committed write; valid while wr_stb=1.
REQ-012 Port: miso  output  1  serial readback, MSB first.

Function
REQ-013 The block SHALL hold bit_cnt (3-bit, wrapping) and byte_cnt (2-bit, saturating at 2), both incremented on each edge with cs=1; byte_cnt increments when bit_cnt wraps 7->0.
REQ-014 On any edge with cs=0, bit_cnt, byte_cnt and wr_stb SHALL clear to 0 and miso SHALL drive 0; registers SHALL be unchanged.
REQ-015 Event L (load) SHALL occur on an edge with cs=1, bit_cnt=0 and byte_cnt>=1, which is spi_clk edge 9, 17, 25... of a frame.
REQ-016 Event W (write) SHALL occur on an L edge with byte_cnt=2 and is_write=1, so the first write is on edge 17.
REQ-017 On W, the write target SHALL be T = addr - 1 mod 128, so addr 0 gives T = 127.
REQ-018 On W with T < NUM_REGS, reg[T] SHALL take wdata, wr_stb SHALL be 1 and wr_addr SHALL be T for exactly that cycle.
REQ-019 On W with T >= NUM_REGS, the write SHALL be discarded and wr_stb SHALL stay 0.
REQ-020 On an L edge with is_write=0, the read shifter SHALL load reg[addr] (8'h00 if addr >= NUM_REGS) and miso SHALL present bit 7.
REQ-021 The read shifter SHALL present bits 6..0 on the next 7 edges, giving auto-incrementing burst reads.
REQ-022 A frame ended (cs=0) mid-byte SHALL produce no write for the partial byte; previously committed bytes SHALL persist.
REQ-023 Write latency SHALL be: regs_out reflects wdata in the cycle immediately after the W edge.

Reset
REQ-024 While rstn=0: all registers SHALL be RST_VAL, bit_cnt=0, byte_cnt=0, wr_stb=0, wr_addr=0 and miso=0, asynchronously.
REQ-025 Reset asserted mid-frame SHALL abort the frame, and no write SHALL occur on the edge of reset release.

Configuration
REQ-026 With SPI_READBACK_EN defined, the read shifter and REQ-020/021 SHALL be implemented.
REQ-027 Without SPI_READBACK_EN, miso SHALL be constant 0 with no shifter logic; the write path SHALL be identical.

Structure
REQ-028 NUM_REGS default, RST_VAL default, the address width (7) and the byte width (8) SHALL live in shared package spi_pkg.
REQ-029 The read shifter SHALL be sub-module spi_miso_shifter (load, shift, 8-bit data, miso out), instantiated only under SPI_READBACK_EN.

Verification
REQ-030 Write frame: addr byte 0x85, then data 0x3C.
- Drive addr=7'h06 and wdata=8'h3C at edge 17.
- Require wr_stb=1, wr_addr=5, and reg[5]=0x3C on the next cycle.
REQ-031 Burst write: 3 data bytes starting at target 0x1F with NUM_REGS=32.
- Require reg[31] written.
- Require the bytes targeting 32 and 33 discarded with no wr_stb.
REQ-032 Read frame: reg[4]=0xA5 and reg[5]=0x0F, is_write=0, addr=4 at edge 9 and 5 at edge 17.
- Require miso sequence 1,0,1,0,0,1,0,1 then 0,0,0,0,1,1,1,1.
REQ-033 Wrap: is_write=1, addr=0 at edge 17.
- Require the write to T=127 discarded (NUM_REGS=32).
- Require bit_cnt=0 after the frame.
REQ-034 Abort: cs dropped at edge 14.
- Require no wr_stb.
- Require registers unchanged and miso=0.
REQ-035 Reset mid-frame: rstn pulsed low at edge 20 of a write burst.
- Require all registers at RST_VAL immediately.
- Require no write on the edge after release.
